inv_cipher_iter: RTL and testbench

- Iterative AES-128 inverse cipher (decryption). It computes one round per clock and is the receive-side counterpart of the team's iterative encrypt datapath.
- Accepts a 128-bit ciphertext and the 1408-bit expanded key schedule through a valid/ready handshake. Returns the plaintext through a valid/ready handshake.
- Sits between the key-expansion block, which supplies w, and the downstream consumer.

---
 rtl/aes_pkg.sv | 62 ++++++
 rtl/inv_round.sv | 41 ++++
 rtl/inv_cipher_iter.sv | 90 +++++++++
 tb/tb_inv_cipher_iter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 constants, FSM encoding and GF(2^8) helpers used by the
// iterative inverse cipher and its round datapath.
package aes_pkg;

    localparam int NB      = 4;
    localparam int NK      = 4;
    localparam int NR      = 10;
    localparam int BLOCK_W = 128;
    localparam int KS_W    = 1408;

    typedef logic [1:0] fsm_t;

    localparam logic [1:0] FSM_IDLE  = 2'd0;
    localparam logic [1:0] FSM_ROUND = 2'd1;
    localparam logic [1:0] FSM_FINAL = 2'd2;
    localparam logic [1:0] FSM_DONE  = 2'd3;

    // Byte b of the inverse S-box sits at bits [2047-8*b -: 8].
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[2047 - 8*int'(b) -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul9(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] mul11(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] mul13(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] mul14(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

endpackage

// File: rtl/inv_round.sv
// One combinational inverse round: InvShiftRows, InvSubBytes, AddRoundKey and,
// when mix_en is set, InvMixColumns. Byte i of a block is bits [127-8*i -: 8].
module inv_round
    import aes_pkg::*;
(
    input  logic [BLOCK_W-1:0] state_in,
    input  logic [BLOCK_W-1:0] rk,
    input  logic               mix_en,
    output logic [BLOCK_W-1:0] state_out
);

    logic [7:0] sb [16];
    logic [7:0] ak [16];
    logic [7:0] mx [16];

    always_comb begin
        sb = '{default: 8'h00};
        ak = '{default: 8'h00};
        mx = '{default: 8'h00};
        state_out = '0;
        // Byte (row r, col c) is 4*c+r; row r rotates right by r columns.
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sb[4*c+r] = inv_sbox(state_in[127 - 8*(4*((c - r + 4) % 4) + r) -: 8]);
            end
        end
        for (int i = 0; i < 16; i++) begin
            ak[i] = sb[i] ^ rk[127 - 8*i -: 8];
        end
        for (int c = 0; c < 4; c++) begin
            mx[4*c+0] = mul14(ak[4*c]) ^ mul11(ak[4*c+1]) ^ mul13(ak[4*c+2]) ^ mul9(ak[4*c+3]);
            mx[4*c+1] = mul9(ak[4*c])  ^ mul14(ak[4*c+1]) ^ mul11(ak[4*c+2]) ^ mul13(ak[4*c+3]);
            mx[4*c+2] = mul13(ak[4*c]) ^ mul9(ak[4*c+1])  ^ mul14(ak[4*c+2]) ^ mul11(ak[4*c+3]);
            mx[4*c+3] = mul11(ak[4*c]) ^ mul13(ak[4*c+1]) ^ mul9(ak[4*c+2])  ^ mul14(ak[4*c+3]);
        end
        for (int i = 0; i < 16; i++) begin
            state_out[127 - 8*i -: 8] = mix_en ? mx[i] : ak[i];
        end
    end

endmodule

// File: rtl/inv_cipher_iter.sv
// Iterative AES-128 decryption: one inverse round per clock between a
// ciphertext/key-schedule input handshake and a plaintext output handshake.
module inv_cipher_iter #(
    parameter int NR = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [127:0]  ct,
    input  logic [1407:0] w,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [127:0]  pt,
    output logic [1:0]    dbg_fsm
);
    import aes_pkg::*;

    // Valid/ready: a transfer happens on a posedge with valid && ready both high.
    // in_ready depends only on the state register; out_valid is held until out_ready.
    fsm_t               fsm;
    logic [3:0]         round;
    logic [BLOCK_W-1:0] state;
    logic [BLOCK_W-1:0] rk_sel;
    logic [BLOCK_W-1:0] rnd_out;

    assign in_ready = (fsm == FSM_IDLE);
    assign dbg_fsm  = fsm;

    // round reaches 0 by the time FINAL runs, so the same mux yields rk0 there.
    always_comb begin
        rk_sel = '0;
        for (int k = 0; k <= NR; k++) begin
            if (round == 4'(k)) begin
                rk_sel = w[KS_W - 1 - BLOCK_W*k -: BLOCK_W];
            end
        end
    end

    inv_round u_inv_round (
        .state_in  (state),
        .rk        (rk_sel),
        .mix_en    (fsm == FSM_ROUND),
        .state_out (rnd_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm       <= FSM_IDLE;
            round     <= 4'd0;
            state     <= '0;
            pt        <= '0;
            out_valid <= 1'b0;
        end else begin
            case (fsm)
                FSM_IDLE: begin
                    if (in_valid) begin
                        state <= ct ^ w[BLOCK_W-1:0];
                        round <= 4'(NR - 1);
                        fsm   <= FSM_ROUND;
                    end
                end
                FSM_ROUND: begin
                    if (round == 4'd0 || round > 4'(NR - 1)) begin
                        fsm <= FSM_IDLE;
                    end else begin
                        state <= rnd_out;
                        round <= round - 4'd1;
                        if (round == 4'd1) begin
                            fsm <= FSM_FINAL;
                        end
                    end
                end
                FSM_FINAL: begin
                    pt        <= rnd_out;
                    out_valid <= 1'b1;
                    fsm       <= FSM_DONE;
                end
                FSM_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        fsm       <= FSM_IDLE;
                    end
                end
                default: fsm <= FSM_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inv_cipher_iter.sv
// Self-checking bench for inv_cipher_iter: FIPS-197 vectors, backpressure,
// busy-ignore, mid-operation reset and back-to-back random vectors.
module tb_inv_cipher_iter;
    import aes_pkg::*;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [127:0]  ct_i;
    logic [1407:0] w_i;
    logic          out_valid;
    logic          out_ready;
    logic [127:0]  pt;
    logic [1:0]    dbg_fsm;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int n_out    = 0;
    logic [127:0] exp_q[$];

    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    inv_cipher_iter dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ct        (ct_i),
        .w         (w_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pt        (pt),
        .dbg_fsm   (dbg_fsm)
    );

    // Clock and cycle counter
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Forward AES reference: key expansion and encryption
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[2047 - 8*int'(b) -: 8];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [1407:0] expand(input logic [127:0] key);
        logic [31:0]   wd [44];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [1407:0] r;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) wd[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = wd[i-1];
            if (i % 4 == 0) begin
                t = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            wd[i] = wd[i-4] ^ t;
        end
        r = '0;
        for (int i = 0; i < 44; i++) r[1407 - 32*i -: 32] = wd[i];
        return r;
    endfunction

    function automatic logic [127:0] encrypt(input logic [127:0] p, input logic [1407:0] ks);
        logic [127:0] s;
        logic [7:0]   a [16];
        logic [7:0]   b [16];
        s = p ^ ks[1407:1280];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    a[4*c+r] = sbox(s[127 - 8*(4*((c + r) % 4) + r) -: 8]);
            for (int c = 0; c < 4; c++) begin
                if (rnd < 10) begin
                    b[4*c+0] = xt(a[4*c]) ^ xt(a[4*c+1]) ^ a[4*c+1] ^ a[4*c+2] ^ a[4*c+3];
                    b[4*c+1] = a[4*c] ^ xt(a[4*c+1]) ^ xt(a[4*c+2]) ^ a[4*c+2] ^ a[4*c+3];
                    b[4*c+2] = a[4*c] ^ a[4*c+1] ^ xt(a[4*c+2]) ^ xt(a[4*c+3]) ^ a[4*c+3];
                    b[4*c+3] = xt(a[4*c]) ^ a[4*c] ^ a[4*c+1] ^ a[4*c+2] ^ xt(a[4*c+3]);
                end else begin
                    for (int r = 0; r < 4; r++) b[4*c+r] = a[4*c+r];
                end
            end
            for (int i = 0; i < 16; i++) s[127 - 8*i -: 8] = b[i];
            s = s ^ ks[1407 - 128*rnd -: 128];
        end
        return s;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Driver tasks; each starts and ends 1 time unit after a posedge
    task automatic send(input logic [127:0] c, input logic [1407:0] k,
                        input logic [127:0] exp, output int acc);
        int n = 0;
        in_valid = 1'b1;
        ct_i     = c;
        w_i      = k;
        while (!in_ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("accept_timeout", in_ready, 1'b1);
        @(posedge clk);
        if (in_ready) exp_q.push_back(exp);
        #1;
        acc      = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int oc);
        int n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("out_valid_timeout", out_valid, 1'b1);
        oc = cyc;
    endtask

    // Scoreboard: pop on every output handshake
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_out++;
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_output observed=%h expected=none", pt);
            end
            if (exp_q.size() != 0) check("pt", pt, exp_q.pop_front());
        end
    end

    initial begin
        logic [1407:0] ks_c1;
        logic [1407:0] ks;
        logic [127:0]  p;
        logic [127:0]  c;
        int acc;
        int oc;
        int prev_acc;
        int n_before;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; ct_i = '0; w_i = '0;
        ks_c1 = expand(KEY_C1);
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_pt", pt, '0);
        check("rst_fsm", dbg_fsm, FSM_IDLE);
        rst = 1'b0;

        // FIPS-197 C.1
        send(CT_C1, ks_c1, PT_C1, acc);
        wait_out(oc);
        check("c1_latency", oc - acc, 10);
        @(posedge clk); #1;
        check("c1_ready_back", in_ready, 1'b1);

        // Appendix B with 20 cycles of backpressure
        out_ready = 1'b0;
        send(CT_B, expand(KEY_B), PT_B, acc);
        wait_out(oc);
        check("b_latency", oc - acc, 10);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check("bp_out_valid", out_valid, 1'b1);
            check("bp_pt", pt, PT_B);
            check("bp_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_in_ready", in_ready, 1'b1);
        check("bp_release_out_valid", out_valid, 1'b0);
        check("pt_hold_after_consume", pt, PT_B);

        // Busy ignore: in_valid pulses sampled at acceptance+3 and +7
        send(CT_C1, ks_c1, PT_C1, acc);
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b1; ct_i = ~CT_C1;
        check("busy3_in_ready", in_ready, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b1; ct_i = CT_B;
        check("busy7_in_ready", in_ready, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_out(oc);
        check("busy_latency", oc - acc, 10);
        n_before = n_out;
        repeat (20) @(posedge clk);
        #1;
        check("busy_single_output", n_out, n_before + 1);
        check("busy_queue_empty", exp_q.size(), 0);

        // Reset during round 5
        send(CT_C1, ks_c1, PT_C1, acc);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        void'(exp_q.pop_back());
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_in_ready", in_ready, 1'b1);
        check("midrst_pt", pt, '0);
        check("midrst_fsm", dbg_fsm, FSM_IDLE);
        send(CT_C1, ks_c1, PT_C1, acc);
        wait_out(oc);
        check("midrst_c1_latency", oc - acc, 10);
        @(posedge clk); #1;

        // Back-to-back random vectors against the forward reference
        out_ready = 1'b1;
        prev_acc  = 0;
        for (int v = 0; v < 4; v++) begin
            p  = {$urandom(), $urandom(), $urandom(), $urandom()};
            ks = expand({$urandom(), $urandom(), $urandom(), $urandom()});
            c  = encrypt(p, ks);
            send(c, ks, p, acc);
            if (v > 0) check("b2b_spacing", acc - prev_acc, 12);
            prev_acc = acc;
            wait_out(oc);
            check("b2b_latency", oc - acc, 10);
        end
        repeat (3) @(posedge clk);
        #1;
        check("final_queue_empty", exp_q.size(), 0);
        check("final_output_count", n_out, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
